pe_acc_cswitch: RTL and testbench

//  Per-PE accumulator stage directly downstream of the PE adder. It registers the adder sum and

---
 rtl/pe_acc_cswitch_if.sv | 26 ++
 rtl/pe_acc_cswitch.sv | 73 +++++++
 tb/tb_pe_acc_cswitch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pe_acc_cswitch_if.sv
// Adder-side, control and drain-chain signals of one PE accumulator stage.
// The master modport drives the stage inputs; the slave modport is the stage itself.
interface pe_acc_cswitch_if #(
    parameter int OC_W = 16
);
    logic            i_en;
    logic            i_acc_valid;
    logic [OC_W-1:0] i_sum;
    logic            i_cswitch;
    logic            i_shift;
    logic [OC_W-1:0] i_chain;
    logic [OC_W-1:0] o_c;
    logic [OC_W-1:0] o_chain;
    logic            o_busy;
    logic            o_err;

    modport master (
        output i_en, i_acc_valid, i_sum, i_cswitch, i_shift, i_chain,
        input  o_c, o_chain, o_busy, o_err
    );

    modport slave (
        input  i_en, i_acc_valid, i_sum, i_cswitch, i_shift, i_chain,
        output o_c, o_chain, o_busy, o_err
    );
endinterface

// File: rtl/pe_acc_cswitch.sv
// Output-stationary PE accumulator with a context-switch shadow register
// that forms one stage of a per-column result drain chain.
module pe_acc_cswitch #(
    parameter int OC_W      = 16,
    parameter int CHAIN_LEN = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pe_acc_cswitch_if.slave      bus
);
    localparam int CW = $clog2(CHAIN_LEN + 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    logic [OC_W-1:0] acc, acc_d;
    logic [OC_W-1:0] shadow, shadow_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            err, err_d;
    logic            mac;
    state_t          state;

    // The drain counter is the state register; the enum is its decoded view.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc    <= '0;
            shadow <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            acc    <= acc_d;
            shadow <= shadow_d;
            cnt    <= cnt_d;
            err    <= err_d;
        end
    end

    always_comb begin
        state    = (cnt != '0) ? DRAIN : IDLE;
        mac      = bus.i_en & bus.i_acc_valid;
        acc_d    = acc;
        shadow_d = shadow;
        cnt_d    = cnt;
        err_d    = err;

        if (bus.i_cswitch) begin
            // A MAC landing in the switch cycle belongs to the finished tile.
            acc_d    = '0;
            shadow_d = mac ? bus.i_sum : acc;
            cnt_d    = CW'(CHAIN_LEN);
            if (state == DRAIN) begin
                err_d = 1'b1;
            end
        end else begin
            if (mac) begin
                acc_d = bus.i_sum;
            end
            if (bus.i_shift) begin
                shadow_d = bus.i_chain;
                if (state == DRAIN) begin
                    cnt_d = cnt - 1'b1;
                end
            end
        end
    end

    assign bus.o_c     = acc;
    assign bus.o_chain = shadow;
    assign bus.o_busy  = (cnt != '0);
    assign bus.o_err   = err;
endmodule

// File: tb/tb_pe_acc_cswitch.sv
// Table-driven bench for pe_acc_cswitch with an expected-output scoreboard queue.
module tb_pe_acc_cswitch;
    localparam int OC_W      = 16;
    localparam int CHAIN_LEN = 8;

    typedef struct {
        logic            rst;
        logic            en;
        logic            av;
        logic [OC_W-1:0] sum;
        logic            cs;
        logic            sh;
        logic [OC_W-1:0] chain;
        logic [OC_W-1:0] e_c;
        logic [OC_W-1:0] e_chain;
        logic            e_busy;
        logic            e_err;
    } vec_t;

    typedef struct {
        logic [OC_W-1:0] c;
        logic [OC_W-1:0] chain;
        logic            busy;
        logic            err;
        int              idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    vec_t vecs[$];
    exp_t sb[$];

    pe_acc_cswitch_if #(.OC_W(OC_W)) bus ();

    pe_acc_cswitch #(
        .OC_W      (OC_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic en, input logic av,
                                input logic [OC_W-1:0] sum, input logic cs,
                                input logic sh, input logic [OC_W-1:0] chain,
                                input logic [OC_W-1:0] e_c, input logic [OC_W-1:0] e_chain,
                                input logic e_busy, input logic e_err);
        vec_t v;
        v.rst = r; v.en = en; v.av = av; v.sum = sum; v.cs = cs; v.sh = sh;
        v.chain = chain; v.e_c = e_c; v.e_chain = e_chain; v.e_busy = e_busy; v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [OC_W-1:0] act,
                       input logic [OC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle, push its expectation, then pop and compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        rst              = v.rst;
        bus.i_en         = v.en;
        bus.i_acc_valid  = v.av;
        bus.i_sum        = v.sum;
        bus.i_cswitch    = v.cs;
        bus.i_shift      = v.sh;
        bus.i_chain      = v.chain;
        e.c = v.e_c; e.chain = v.e_chain; e.busy = v.e_busy; e.err = v.e_err; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
        end else begin
            got = sb.pop_front();
            chk("o_c",     got.idx, bus.o_c,     got.c);
            chk("o_chain", got.idx, bus.o_chain, got.chain);
            chk("o_busy",  got.idx, OC_W'(bus.o_busy), OC_W'(got.busy));
            chk("o_err",   got.idx, OC_W'(bus.o_err),  OC_W'(got.err));
        end
    endtask

    initial begin
        vec_t v;
        // T1: reset with random inputs for two cycles
        for (int k = 0; k < 2; k++) begin
            v.rst = 1'b1;
            v.en = 1'($urandom); v.av = 1'($urandom); v.sum = OC_W'($urandom);
            v.cs = 1'($urandom); v.sh = 1'($urandom); v.chain = OC_W'($urandom);
            v.e_c = '0; v.e_chain = '0; v.e_busy = 1'b0; v.e_err = 1'b0;
            vecs.push_back(v);
        end
        // T2: accumulate and hold
        add(0, 1, 1, 16'd5,    0, 0, 16'h0, 16'd5,    16'h0, 0, 0);
        add(0, 1, 1, 16'd12,   0, 0, 16'h0, 16'd12,   16'h0, 0, 0);
        add(0, 1, 1, 16'hFFFF, 0, 0, 16'h0, 16'hFFFF, 16'h0, 0, 0);
        add(0, 0, 1, 16'd7,    0, 0, 16'h0, 16'hFFFF, 16'h0, 0, 0);
        add(0, 1, 0, 16'd9,    0, 0, 16'h0, 16'hFFFF, 16'h0, 0, 0);
        // T3: cswitch with a final MAC in the same cycle
        add(0, 1, 1, 16'd100,  0, 0, 16'h0, 16'd100,  16'h0, 0, 0);
        add(0, 1, 1, 16'd107,  1, 0, 16'h0, 16'h0,    16'd107, 1, 0);
        // T4: full drain, then a 9th shift with cnt already 0
        for (int k = 0; k < CHAIN_LEN; k++)
            add(0, 0, 0, 16'h0, 0, 1, 16'hA0 + 16'(k), 16'h0, 16'hA0 + 16'(k), (k < CHAIN_LEN - 1), 0);
        add(0, 0, 0, 16'h0,    0, 1, 16'h55, 16'h0,  16'h55, 0, 0);
        add(0, 1, 1, 16'd3,    0, 0, 16'h0,  16'd3,  16'h55, 0, 0);
        // T5: cswitch from idle, 3 shifts, then overlapping cswitch with same-cycle shift
        add(0, 0, 0, 16'h0,    1, 0, 16'h0,  16'h0,  16'd3,  1, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 16'h0, 0, 1, 16'hB0 + 16'(k), 16'h0, 16'hB0 + 16'(k), 1, 0);
        add(0, 1, 1, 16'd20,   0, 0, 16'h0,  16'd20, 16'hB2, 1, 0);
        add(0, 1, 0, 16'h0,    1, 1, 16'h77, 16'h0,  16'd20, 1, 1);
        // Reloaded count needs exactly CHAIN_LEN more shifts; err stays sticky
        for (int k = 0; k < CHAIN_LEN; k++)
            add(0, 0, 0, 16'h0, 0, 1, 16'hC0 + 16'(k), 16'h0, 16'hC0 + 16'(k), (k < CHAIN_LEN - 1), 1);
        // T6: reset mid-drain (cnt=5, acc=42) with every other input active
        add(1, 0, 0, 16'h0,    0, 0, 16'h0,  16'h0,  16'h0,  0, 0);
        add(0, 1, 1, 16'd42,   0, 0, 16'h0,  16'd42, 16'h0,  0, 0);
        add(0, 0, 0, 16'h0,    1, 0, 16'h0,  16'h0,  16'd42, 1, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 16'h0, 0, 1, 16'hD0 + 16'(k), 16'h0, 16'hD0 + 16'(k), 1, 0);
        add(0, 1, 1, 16'd42,   0, 0, 16'h0,  16'd42, 16'hD2, 1, 0);
        add(1, 1, 1, 16'd99,   1, 1, 16'h11, 16'h0,  16'h0,  0, 0);
        add(0, 0, 0, 16'h0,    0, 0, 16'h0,  16'h0,  16'h0,  0, 0);

        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i], i);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
